sync_fifo_mc: RTL and testbench
===============================

SYNC_FIFO_MC -- requirements
Module: sync_fifo_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entries per channel; power of two, >=2.
REQ-003 SHALL have parameter NUM_CH, default 4: number of independent channels, >=1.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2: per-channel almost-full level.
REQ-005 SHALL derive localparams AW = $clog2(DEPTH) and CW = max(1, $clog2(NUM_CH)).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_ch  input  CW  target channel of the write.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_ch  input  CW  source channel of the read.
REQ-013 rd_valid  output  1  dout holds data popped the previous cycle.
REQ-014 dout  output  DATA_WIDTH  read data, registered.
REQ-015 full  output  NUM_CH  per-channel full flag, bit i = channel i.
REQ-016 empty  output  NUM_CH  per-channel empty flag.
REQ-017 afull  output  NUM_CH  per-channel count >= AFULL_THRESH.
REQ-018 count  output  NUM_CH*(AW+1)  per-channel occupancy, channel i at bits [i*(AW+1) +: AW+1].
REQ-019 ovf, udf  output  NUM_CH each  sticky overflow/underflow flags.
REQ-020 err_clr  input  1  clears all ovf/udf bits.

Function
REQ-021 Each channel SHALL be an independent circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-022 A write SHALL be accepted when wr_en=1, wr_ch<NUM_CH and the channel is not full; data is stored and the write pointer advances at that edge.
REQ-023 A read SHALL be accepted when rd_en=1, rd_ch<NUM_CH and the channel is not empty; dout updates and rd_valid=1 on the next cycle (latency 1).
REQ-024 Without an accepted read, rd_valid SHALL be 0 next cycle and dout SHALL hold its previous value.
REQ-025 Requests with channel index >=NUM_CH SHALL be ignored with no state change.
REQ-026 Write and read on the same non-empty, non-full channel in one cycle SHALL both be accepted; count unchanged.
REQ-027 Write to a full channel with a same-cycle accepted read on that channel SHALL be accepted; count stays DEPTH.
REQ-028 Read of an empty channel with a same-cycle write to it SHALL be rejected (no bypass); the write is accepted.
REQ-029 Write and read on different channels in one cycle SHALL both be processed independently.
REQ-030 full[i], empty[i], afull[i] and count SHALL be registered and reflect state after the current edge, with no lag.
REQ-031 count SHALL range 0..DEPTH inclusive; full[i]=(count==DEPTH), empty[i]=(count==0).

Reset
REQ-032 On rst=1 at a rising edge, all pointers and counts SHALL be 0, empty all 1, full and afull all 0, rd_valid 0, dout 0, ovf/udf 0.
REQ-033 rst SHALL take priority over any same-cycle wr_en/rd_en; in-flight data is discarded and storage contents need not be reset.

Configuration
REQ-034 Macro SYNC_FIFO_MC_ERR_EN SHALL enable error tracking.
REQ-035 Defined: a rejected write to full channel i sets ovf[i]; a rejected read of empty channel i sets udf[i] (REQ-028 case included); err_clr=1 clears all; a same-cycle set wins over clear.
REQ-036 Undefined: ovf and udf SHALL be tied to 0, err_clr ignored; all other behaviour identical.

Verification
REQ-037 Reset, write 16 words 0x00..0x0F to ch2, read 16 from ch2 -> dout 0x00..0x0F in order, each one cycle after rd_en; full[2]=1 after 16th write, empty[2]=1 after last read.
REQ-038 Interleave writes to ch0 (0xA0..) and ch3 (0xB0..), read alternately -> each channel returns its own sequence; count of ch1/ch2 stays 0.
REQ-039 Fill ch1 to 16, then wr_en+rd_en on ch1 for 20 cycles -> every write accepted, count stays 16, data order preserved across pointer wrap.
REQ-040 With SYNC_FIFO_MC_ERR_EN: write ch0 when full -> ovf[0]=1, data dropped; read empty ch1 -> udf[1]=1, rd_valid=0; err_clr pulse -> both 0.
REQ-041 Empty ch0, same-cycle wr_en/rd_en on ch0 with din=0x55 -> rd_valid=0 next cycle, count=1; next read returns 0x55.
REQ-042 Assert rst mid-burst with 7 words in ch2 and wr_en=1 -> next cycle count=0, empty all 1, rd_valid=0, dout=0.

Source files
------------

// File: rtl/sync_fifo_mc.sv
// Multi-channel synchronous FIFO: NUM_CH independent circular buffers sharing one write and one read port.
// Optional sticky overflow/underflow tracking is enabled by defining SYNC_FIFO_MC_ERR_EN.
module sync_fifo_mc #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CW-1:0]            wr_ch,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [CW-1:0]            rd_ch,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        afull,
  output logic [NUM_CH*(AW+1)-1:0] count,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        udf,
  input  logic                     err_clr
);

  localparam int unsigned CNTW = AW + 1;

  logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
  logic [AW-1:0]         wr_ptr [NUM_CH];
  logic [AW-1:0]         rd_ptr [NUM_CH];
  logic [CNTW-1:0]       cnt_q  [NUM_CH];
  logic [CNTW-1:0]       cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]     wr_acc;
  logic [NUM_CH-1:0]     rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Per-channel accept decisions; out-of-range channel indices match no channel and are dropped.
  always_comb begin
    cnt_q   = '{default: '0};
    cnt_d   = '{default: '0};
    wr_acc  = '0;
    rd_acc  = '0;
    rd_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_q[i]  = count[i*CNTW +: CNTW];
      rd_acc[i] = rd_en && (rd_ch == CW'(i)) && (cnt_q[i] != '0);
      // A full channel still takes a write when the same cycle pops from it.
      wr_acc[i] = wr_en && (wr_ch == CW'(i)) && ((cnt_q[i] != CNTW'(DEPTH)) || rd_acc[i]);
      cnt_d[i]  = cnt_q[i] + CNTW'(wr_acc[i]) - CNTW'(rd_acc[i]);
      if (rd_acc[i]) rd_data = mem[i][rd_ptr[i]];
    end
  end

  // Pointers, occupancy, flags and read port; flags are computed from the post-edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      full     <= '0;
      empty    <= '1;
      afull    <= '0;
      rd_valid <= 1'b0;
      dout     <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      rd_valid <= |rd_acc;
      if (|rd_acc) dout <= rd_data;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (wr_acc[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_acc[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i*CNTW +: CNTW] <= cnt_d[i];
        full[i]  <= (cnt_d[i] == CNTW'(DEPTH));
        empty[i] <= (cnt_d[i] == '0);
        afull[i] <= (cnt_d[i] >= CNTW'(AFULL_THRESH));
      end
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!rst && wr_acc[i]) mem[i][wr_ptr[i]] <= din;
    end
  end

`ifdef SYNC_FIFO_MC_ERR_EN
  logic [NUM_CH-1:0] wr_rej;
  logic [NUM_CH-1:0] rd_rej;

  always_comb begin
    wr_rej = '0;
    rd_rej = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      wr_rej[i] = wr_en && (wr_ch == CW'(i)) && !wr_acc[i];
      rd_rej[i] = rd_en && (rd_ch == CW'(i)) && !rd_acc[i];
    end
  end

  // Sticky error bits; a new event in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
      udf <= '0;
    end else begin
      ovf <= (err_clr ? '0 : ovf) | wr_rej;
      udf <= (err_clr ? '0 : udf) | rd_rej;
    end
  end
`else
  logic unused_err_clr;

  assign ovf            = '0;
  assign udf            = '0;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Randomized and directed bench for sync_fifo_mc against a per-channel queue model.
// Error-flag expectations follow SYNC_FIFO_MC_ERR_EN.
module tb_sync_fifo_mc;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int AW    = 4;
  localparam int CW    = 2;
  localparam int AFT   = DEPTH - 2;

  logic                  clk = 1'b0;
  logic                  rst, wr_en, rd_en, err_clr;
  logic [CW-1:0]         wr_ch, rd_ch;
  logic [DW-1:0]         din;
  logic                  rd_valid;
  logic [DW-1:0]         dout;
  logic [NCH-1:0]        full, empty, afull, ovf, udf;
  logic [NCH*(AW+1)-1:0] count;

  sync_fifo_mc dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .din(din),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_valid(rd_valid), .dout(dout),
    .full(full), .empty(empty), .afull(afull), .count(count),
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]     mq [NCH][$];
  logic [7:0]     m_dout;
  logic           m_valid;
  logic [NCH-1:0] m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NCH*(AW+1)-1:0] e_count;
    logic [NCH-1:0]        e_full, e_empty, e_afull;
    e_count = '0; e_full = '0; e_empty = '0; e_afull = '0;
    for (int c = 0; c < NCH; c++) begin
      e_count[c*(AW+1) +: AW+1] = 5'(mq[c].size());
      e_full[c]  = (mq[c].size() == DEPTH);
      e_empty[c] = (mq[c].size() == 0);
      e_afull[c] = (mq[c].size() >= AFT);
    end
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("dout",     32'(dout),     32'(m_dout));
    check("count",    32'(count),    32'(e_count));
    check("full",     32'(full),     32'(e_full));
    check("empty",    32'(empty),    32'(e_empty));
    check("afull",    32'(afull),    32'(e_afull));
    check("ovf",      32'(ovf),      32'(m_ovf));
    check("udf",      32'(udf),      32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then compare.
  task automatic cycle(input logic r, input logic we, input int wc, input logic [7:0] d,
                       input logic re, input int rc, input logic ec);
    logic rd_ok, wr_ok;
    rst = r; wr_en = we; wr_ch = CW'(wc); din = d; rd_en = re; rd_ch = CW'(rc); err_clr = ec;
    @(posedge clk);
    #1;
    if (r) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = '0; m_udf = '0;
    end else begin
      rd_ok = re && (mq[rc].size() > 0);
      wr_ok = we && ((mq[wc].size() < DEPTH) || (rd_ok && rc == wc));
`ifdef SYNC_FIFO_MC_ERR_EN
      if (ec) begin m_ovf = '0; m_udf = '0; end
      if (we && !wr_ok) m_ovf[wc] = 1'b1;
      if (re && !rd_ok) m_udf[rc] = 1'b1;
`endif
      m_valid = rd_ok;
      if (rd_ok) m_dout = mq[rc].pop_front();
      if (wr_ok) mq[wc].push_back(d);
    end
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int wp;
    m_dout = '0; m_valid = 1'b0; m_ovf = '0; m_udf = '0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_ch = '0; rd_ch = '0; din = '0;

    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
    check("rst_empty", 32'(empty), 32'hF);

    // Fill and drain channel 2 in order.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 2, 8'(i), 1'b0, 0, 1'b0);
    check("ch2_full", 32'(full[2]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
      check("ch2_seq", 32'(dout), 32'(i));
    end
    check("ch2_empty", 32'(empty[2]), 32'd1);

    // Interleaved channels 0 and 3.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 0, 8'(8'hA0 + i), 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b1, 3, 8'(8'hB0 + i), 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b0);
      check("ch0_seq", 32'(dout), 32'(8'hA0 + i));
      cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 3, 1'b0);
      check("ch3_seq", 32'(dout), 32'(8'hB0 + i));
    end

    // Full channel 1 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1, 8'(8'h10 + i), 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1, 8'(8'h40 + i), 1'b1, 1, 1'b0);
      check("ch1_wrap", 32'(dout), (i < 16) ? 32'(8'h10 + i) : 32'(8'h40 + i - 16));
      check("ch1_cnt", 32'(count[1*(AW+1) +: AW+1]), 32'd16);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 1'b0);

    // Overflow, underflow and clear.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 0, 8'(8'hC0 + i), 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 8'hEE, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 1'b0);
    check("udf_no_valid", 32'(rd_valid), 32'd0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b0);
    check("ovf_dropped", 32'(dout), 32'hCF);

    // Read of an empty channel with a same-cycle write: no bypass.
    cycle(1'b0, 1'b1, 0, 8'h55, 1'b1, 0, 1'b0);
    check("nobypass_valid", 32'(rd_valid), 32'd0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b0);
    check("nobypass_data", 32'(dout), 32'h55);

    // Reset in the middle of a burst.
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 2, 8'(8'h70 + i), 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
    cycle(1'b1, 1'b1, 2, 8'h99, 1'b1, 2, 1'b0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    idle();

    // Randomized traffic with alternating fill/drain bias.
    for (int n = 0; n < 3000; n++) begin
      wp = ((n / 200) % 2 == 1) ? 75 : 30;
      cycle($urandom_range(199) == 0,
            $urandom_range(99) < wp, int'($urandom_range(NCH - 1)), 8'($urandom),
            $urandom_range(99) < (100 - wp), int'($urandom_range(NCH - 1)),
            $urandom_range(24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
